dmem_arbiter: RTL and testbench

- Shares the single data-memory/IO port (dram plus memory-mapped IO, IO selected by addr[7]) between two requesters: the CPU MEM stage and a DMA/debug master.
- Sequences every access as a fixed two-phase transaction (ADDR, DATA), because the data memory has a registered read.
- Stalls the CPU while the port is busy or granted to DMA.
- Sits between the pipeline MEM stage and the data-memory/IO block.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU MEM stage / DMA) arbiter for the data-memory/IO port; every access is ADDR then DATA.
// Define DMEM_ARB_STARVE_GUARD_EN for the DMA starvation guard and DMA IO-write rejection.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              dma_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic              xfer_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_hold, dma_hold;

  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              dma_cand;
  logic              dma_force;
  logic              reject;
  logic              rd_data;

  assign own_we    = grant ? dma_we    : cpu_we;
  assign own_addr  = grant ? dma_addr  : cpu_addr;
  assign own_wdata = grant ? dma_wdata : cpu_wdata;

  // DMA keeps dma_req high through its own done cycle; that level must not re-grant it.
  assign dma_cand = dma_req & ~((state == DATA) & grant);

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;
  logic             xfer_err;

  assign dma_force = dma_cand & (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign reject    = grant & dma_we & dma_addr[7];
  assign dma_err   = (state == DATA) & grant & xfer_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
      xfer_err   <= 1'b0;
    end else begin
      if (state == ADDR)
        xfer_err <= reject;
      if ((state != ADDR) && (state_nxt == ADDR) && grant_nxt)
        starve_cnt <= '0;
      else if (dma_req && !((state != IDLE) && grant) && (starve_cnt != CNT_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign dma_force = 1'b0;
  assign reject    = 1'b0;
  assign dma_err   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      ADDR: state_nxt = DATA;
      default: begin
        if (cpu_req || dma_cand) begin
          state_nxt = ADDR;
          grant_nxt = dma_force | ~cpu_req;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 1'b0;
      xfer_we  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cpu_hold <= '0;
      dma_hold <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == ADDR) begin
        xfer_we <= own_we;
        addr_q  <= own_addr;
        wdata_q <= own_wdata;
      end
      if (rd_data) begin
        if (grant) dma_hold <= mem_rdata;
        else       cpu_hold <= mem_rdata;
      end
    end
  end

  assign rd_data   = (state == DATA) & ~xfer_we;
  assign mem_we    = (state == ADDR) & own_we & ~reject;
  assign mem_addr  = (state == ADDR) ? own_addr  : addr_q;
  assign mem_wdata = (state == ADDR) ? own_wdata : wdata_q;

  assign cpu_done  = (state == DATA) & ~grant;
  assign dma_done  = (state == DATA) & grant;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign cpu_rdata = (rd_data & ~grant) ? mem_rdata : cpu_hold;
  assign dma_rdata = (rd_data &  grant) ? mem_rdata : dma_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; expectations for both builds of DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_done, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_done, dma_err;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done), .dma_err(dma_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    int done_cyc;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
    repeat (2) @(negedge clock);

    check("rst_cpu_done", cpu_done, 0);
    check("rst_dma_done", dma_done, 0);
    check("rst_dma_err", dma_err, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_stall_lo", cpu_stall, 0);
    cpu_req = 1; #1;
    check("rst_stall_follows", cpu_stall, 1);
    cpu_req = 0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // CPU read of 0x10
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEAD_BEEF;
    #1 check("rd_c0_stall", cpu_stall, 1);
    @(negedge clock);
    check("rd_c1_stall", cpu_stall, 1);
    check("rd_c1_addr", mem_addr, 32'h10);
    check("rd_c1_we", mem_we, 0);
    check("rd_c1_done", cpu_done, 0);
    @(negedge clock);
    check("rd_c2_done", cpu_done, 1);
    check("rd_c2_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("rd_c2_stall", cpu_stall, 0);
    cpu_req = 0;
    @(negedge clock);
    check("rd_c3_done", cpu_done, 0);
    check("rd_c3_addr_hold", mem_addr, 32'h10);
    mem_rdata = 32'h5555_5555;
    #1 check("rd_hold_rdata", cpu_rdata, 32'hDEAD_BEEF);

    // CPU write 0x1234_5678 to 0x4
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h4; cpu_wdata = 32'h1234_5678;
    #1 check("wr_c0_we", mem_we, 0);
    @(negedge clock);
    check("wr_c1_we", mem_we, 1);
    check("wr_c1_addr", mem_addr, 32'h4);
    check("wr_c1_wdata", mem_wdata, 32'h1234_5678);
    check("wr_c1_done", cpu_done, 0);
    @(negedge clock);
    check("wr_c2_we", mem_we, 0);
    check("wr_c2_done", cpu_done, 1);
    check("wr_c2_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 0; cpu_we = 0;
    @(negedge clock);
    check("wr_c3_we", mem_we, 0);
    check("wr_c3_wdata_hold", mem_wdata, 32'h1234_5678);

    // simultaneous CPU and DMA reads
    cpu_req = 1; cpu_addr = 32'h20; dma_req = 1; dma_we = 0; dma_addr = 32'h40;
    mem_rdata = 32'hA5A5_0001;
    @(negedge clock);
    check("both_c1_addr", mem_addr, 32'h20);
    check("both_c1_cdone", cpu_done, 0);
    @(negedge clock);
    check("both_c2_cdone", cpu_done, 1);
    check("both_c2_ddone", dma_done, 0);
    check("both_c2_crdata", cpu_rdata, 32'hA5A5_0001);
    cpu_req = 0;
    @(negedge clock);
    check("both_c3_addr", mem_addr, 32'h40);
    check("both_c3_ddone", dma_done, 0);
    check("both_c3_cdone", cpu_done, 0);
    mem_rdata = 32'h0BAD_F00D;
    @(negedge clock);
    check("both_c4_ddone", dma_done, 1);
    check("both_c4_drdata", dma_rdata, 32'h0BAD_F00D);
    check("both_c4_crdata", cpu_rdata, 32'hA5A5_0001);
    dma_req = 0;
    @(negedge clock);
    check("both_c5_ddone", dma_done, 0);

    // CPU holds its request continuously while DMA waits
    cpu_req = 1; cpu_addr = 32'h8; dma_req = 1; dma_we = 0; dma_addr = 32'h44;
    done_cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (dma_done) begin
        if (done_cyc < 0) done_cyc = i;
        dma_req = 0;
      end
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    check("starve_done_cycle", done_cyc, 10);
`else
    check("starve_never_done", done_cyc, -1);
`endif
    cpu_req = 0; dma_req = 0;
    repeat (3) @(negedge clock);
    check("starve_idle_done", cpu_done | dma_done, 0);

    // DMA write into IO space
    dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'hCAFE;
    @(negedge clock);
    check("io_c1_addr", mem_addr, 32'h80);
`ifdef DMEM_ARB_STARVE_GUARD_EN
    check("io_c1_we", mem_we, 0);
`else
    check("io_c1_we", mem_we, 1);
`endif
    @(negedge clock);
    check("io_c2_done", dma_done, 1);
`ifdef DMEM_ARB_STARVE_GUARD_EN
    check("io_c2_err", dma_err, 1);
`else
    check("io_c2_err", dma_err, 0);
`endif
    check("io_c2_we", mem_we, 0);
    dma_req = 0;
    @(negedge clock);
    check("io_c3_err", dma_err, 0);

    // reset during a DMA write's ADDR phase
    dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'h7777;
    @(negedge clock);
    check("rstw_c1_we", mem_we, 1);
    check("rstw_c1_addr", mem_addr, 32'h30);
    reset = 1'b1; dma_req = 0; dma_we = 0;
    @(negedge clock);
    check("rstw_we", mem_we, 0);
    check("rstw_ddone", dma_done, 0);
    check("rstw_cdone", cpu_done, 0);
    check("rstw_err", dma_err, 0);
    check("rstw_addr", mem_addr, 0);
    check("rstw_wdata", mem_wdata, 0);
    check("rstw_crdata", cpu_rdata, 0);
    check("rstw_drdata", dma_rdata, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rstw_post_ddone", dma_done, 0);
    check("rstw_post_we", mem_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
